// File: rtl/tdc_readout.sv
// Sequential readout of a TDC carry-chain sample RAM: each word is fetched,
// thermometer-decoded into a length plus a bubble flag, and offered downstream.
module tdc_readout #(
  parameter int N_BITS  = 16,
  parameter int N_WORDS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic [$clog2(N_WORDS)-1:0]   rd_addr,
  output logic                         rd_en,
  input  logic [N_BITS-1:0]            rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_WORDS)-1:0]   out_addr,
  output logic [$clog2(N_BITS+1)-1:0]  out_count,
  output logic                         out_bubble,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = $clog2(N_WORDS);
  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [AW-1:0] LAST_INDEX = AW'(N_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    FINISH
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [AW-1:0]  index;
  logic [CW-1:0]  dec_count;
  logic           dec_bubble;
  logic           seen_zero;

  // Thermometer decode: run length of 1s from bit 0, and any 1 past the first 0.
  // NOTE: combinational blocks use blocking '=' so each loop iteration sees the
  // previous one's result; every output gets a default first so no latch forms.
  always_comb begin
    dec_count  = '0;
    dec_bubble = 1'b0;
    seen_zero  = 1'b0;
    for (int i = 0; i < N_BITS; i++) begin
      if (rd_data[i]) begin
        if (seen_zero) dec_bubble = 1'b1;
        else           dec_count  = dec_count + CW'(1);
      end else begin
        seen_zero = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = HOLD;
      HOLD:    if (out_ready) state_next = (index == LAST_INDEX) ? FINISH : ISSUE;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from
  // the same pre-edge values; reset is synchronous and clears every register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_count  <= '0;
      out_bubble <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            index <= '0;
            done  <= 1'b0;
          end
        end
        WAIT: begin
          out_valid  <= 1'b1;
          out_addr   <= index;
          out_count  <= dec_count;
          out_bubble <= dec_bubble;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (index != LAST_INDEX) index <= index + AW'(1);
          end
        end
        FINISH:  done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Read port and status are pure decodes of the registered state.
  assign rd_en   = (state == ISSUE);
  assign rd_addr = index;
  assign busy    = (state == ISSUE) || (state == WAIT) || (state == HOLD);

endmodule

// File: tb/tb_tdc_readout.sv
// Directed bench for tdc_readout: stimulus pushes hand-computed results into a
// scoreboard queue; a monitor pops and compares on each output handshake.
module tb_tdc_readout;

  localparam int N_BITS  = 16;
  localparam int N_WORDS = 8;

  typedef struct packed {
    logic [2:0] addr;
    logic [4:0] count;
    logic       bubble;
  } result_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  rd_addr;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_addr;
  logic [4:0]  out_count;
  logic        out_bubble;
  logic        busy;
  logic        done;

  logic [15:0] mem [N_WORDS];
  int          exp_cnt [N_WORDS];
  int          exp_bub [N_WORDS];
  result_t     sb [$];

  int checks;
  int errors;
  int hs_count;
  int expected_total;

  tdc_readout #(.N_BITS(N_BITS), .N_WORDS(N_WORDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_count  (out_count),
    .out_bubble (out_bubble),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got addr %0d, expected no result (t=%0t)", out_addr, $time);
      end else begin
        result_t e;
        e = sb.pop_front();
        check("out_addr",   int'(out_addr),   int'(e.addr));
        check("out_count",  int'(out_count),  int'(e.count));
        check("out_bubble", int'(out_bubble), int'(e.bubble));
      end
    end
  end

  // Pattern 0: k-th word is (1<<2k)-1. Pattern 1: decoder edge cases.
  task automatic set_pattern(input int sel);
    logic [15:0] w [N_WORDS];
    int          c [N_WORDS];
    int          b [N_WORDS];
    if (sel == 0) begin
      w = '{16'h0000, 16'h0003, 16'h000F, 16'h003F, 16'h00FF, 16'h03FF, 16'h0FFF, 16'h3FFF};
      c = '{0, 2, 4, 6, 8, 10, 12, 14};
      b = '{0, 0, 0, 0, 0, 0, 0, 0};
    end else begin
      w = '{16'h0000, 16'hFFFF, 16'h00F7, 16'h8000, 16'h0001, 16'h0005, 16'h7FFF, 16'hFFFE};
      c = '{0, 16, 3, 0, 1, 1, 15, 0};
      b = '{0, 0, 1, 1, 0, 1, 0, 1};
    end
    for (int k = 0; k < N_WORDS; k++) begin
      mem[k]     = w[k];
      exp_cnt[k] = c[k];
      exp_bub[k] = b[k];
    end
  endtask

  task automatic push_expected();
    result_t e;
    for (int k = 0; k < N_WORDS; k++) begin
      e.addr   = 3'(k);
      e.count  = 5'(exp_cnt[k]);
      e.bubble = exp_bub[k][0];
      sb.push_back(e);
    end
    expected_total += N_WORDS;
  endtask

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic start_pass();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; a negative expectation skips the latency check.
  task automatic wait_done(input string name, input int expected_cycles);
    int n;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clock); #1;
      if (done) begin
        n = i;
        break;
      end
    end
    check({name, "_reached"}, int'(n != 0), 1);
    if (expected_cycles >= 0) check({name, "_latency"}, n, expected_cycles);
  endtask

  task automatic wait_word(input int addr);
    int found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (out_valid && out_addr == 3'(addr)) begin
        found = 1;
        break;
      end
    end
    check("wait_word", found, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},      int'(rd_en),      0);
    check({tag, "_rd_addr"},    int'(rd_addr),    0);
    check({tag, "_out_valid"},  int'(out_valid),  0);
    check({tag, "_out_addr"},   int'(out_addr),   0);
    check({tag, "_out_count"},  int'(out_count),  0);
    check({tag, "_out_bubble"}, int'(out_bubble), 0);
    check({tag, "_busy"},       int'(busy),       0);
    check({tag, "_done"},       int'(done),       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; hs_count = 0; expected_total = 0;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    set_pattern(0);
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Clean pass, done latency from the start edge.
    push_expected();
    start_pass();
    check("busy_after_start", int'(busy), 1);
    check("rd_en_issue", int'(rd_en), 1);
    wait_done("pass_clean", 25);
    check("idle_busy", int'(busy), 0);

    // Back-to-back pass with decoder edge words, started right after FINISH.
    set_pattern(1);
    push_expected();
    start_pass();
    check("b2b_done_cleared", int'(done), 0);
    check("b2b_busy", int'(busy), 1);
    wait_done("pass_decoder", 25);

    // Backpressure on word 2 for five cycles.
    set_pattern(0);
    push_expected();
    start_pass();
    wait_word(2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("bp_valid",  int'(out_valid),  1);
      check("bp_addr",   int'(out_addr),   2);
      check("bp_count",  int'(out_count),  4);
      check("bp_bubble", int'(out_bubble), 0);
      check("bp_rd_en",  int'(rd_en),      0);
    end
    out_ready = 1'b1;
    wait_done("pass_backpressure", -1);

    // start while busy at word 3 must be ignored.
    set_pattern(1);
    push_expected();
    start_pass();
    wait_word(3);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_start_busy", int'(busy), 1);
    wait_done("pass_busy_start", -1);

    // Reset while holding word 5, then restart from word 0.
    set_pattern(0);
    push_expected();
    start_pass();
    wait_word(5);
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    check_all_zero("midreset");
    reset = 1'b0;
    sb.delete();
    expected_total -= 3;
    repeat (3) @(posedge clock);
    #1;
    check("post_reset_done", int'(done), 0);
    check("post_reset_busy", int'(busy), 0);
    out_ready = 1'b1;
    push_expected();
    start_pass();
    wait_done("pass_restart", 25);

    repeat (2) @(posedge clock);
    #1;
    check("sb_drained", sb.size(), 0);
    check("handshake_total", hs_count, expected_total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
